// File: rtl/esm_config_router_if.sv
// Bundle of the ESM control stream, the per-port payload fan-out and the error counters.
// The slave modport is the router's view; the master modport is the view of the stream source and the config sinks.
interface esm_config_router_if #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned IDX_W       = 6
);
    logic                   S_axis_valid;
    logic [31:0]            S_axis_data;
    logic                   S_axis_last;
    logic                   S_axis_ready;
    logic [NUM_MODULES-1:0] Module_valid;
    logic [31:0]            Module_data;
    logic [7:0]             Module_msg_type;
    logic [IDX_W-1:0]       Module_word_index;
    logic                   Module_last;
    logic [15:0]            Err_bad_magic;
    logic [15:0]            Err_seq;
    logic [15:0]            Err_unknown_module;
    logic [15:0]            Err_short_overlong;

    modport slave (
        input  S_axis_valid, S_axis_data, S_axis_last,
        output S_axis_ready, Module_valid, Module_data, Module_msg_type,
               Module_word_index, Module_last, Err_bad_magic, Err_seq,
               Err_unknown_module, Err_short_overlong
    );

    modport master (
        output S_axis_valid, S_axis_data, S_axis_last,
        input  S_axis_ready, Module_valid, Module_data, Module_msg_type,
               Module_word_index, Module_last, Err_bad_magic, Err_seq,
               Err_unknown_module, Err_short_overlong
    );
endinterface

// File: rtl/esm_config_router.sv
// ESM control message parser: checks magic/sequence/destination and fans the payload
// out to NUM_MODULES config sinks with registered, single-cycle strobes.
module esm_config_router #(
    parameter int unsigned NUM_MODULES       = 4,
    parameter int unsigned MAX_PAYLOAD_WORDS = 64,
    parameter logic [31:0] MAGIC_NUM         = 32'hE5C0_0F1C,
    parameter logic [7:0]  BROADCAST_ID      = 8'hFF,
    parameter int unsigned IDX_W             = (MAX_PAYLOAD_WORDS > 1) ? $clog2(MAX_PAYLOAD_WORDS) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    esm_config_router_if.slave bus
);

    typedef enum logic [2:0] {
        S_MAGIC   = 3'd0,
        S_SEQ     = 3'd1,
        S_HDR     = 3'd2,
        S_PAD     = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DROP    = 3'd5
    } state_e;

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(MAX_PAYLOAD_WORDS - 1);
    localparam logic [NUM_MODULES-1:0] ONE_HOT  = NUM_MODULES'(1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_e                 state_q, state_d;
    logic                   ready_q;
    logic                   seq_valid_q, seq_valid_d;
    logic [31:0]            prev_seq_q, prev_seq_d;
    logic [NUM_MODULES-1:0] mask_q, mask_d;
    logic [7:0]             type_q, type_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MODULES-1:0] valid_q, valid_d;
    logic [31:0]            data_q, data_d;
    logic [7:0]             otype_q, otype_d;
    logic [IDX_W-1:0]       oidx_q, oidx_d;
    logic                   olast_q, olast_d;
    logic [15:0]            bad_magic_q, bad_magic_d;
    logic [15:0]            seq_err_q, seq_err_d;
    logic [15:0]            unknown_q, unknown_d;
    logic [15:0]            short_q, short_d;

    logic       accept_s;
    logic       last_s;
    logic [7:0] hdr_id_s;

    assign accept_s = bus.S_axis_valid & ready_q;
    assign last_s   = bus.S_axis_last;
    assign hdr_id_s = bus.S_axis_data[31:24];

    // State, context and registered output update
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_MAGIC;
            ready_q     <= 1'b0;
            seq_valid_q <= 1'b0;
            prev_seq_q  <= 32'd0;
            mask_q      <= '0;
            type_q      <= 8'd0;
            cnt_q       <= '0;
            valid_q     <= '0;
            data_q      <= 32'd0;
            otype_q     <= 8'd0;
            oidx_q      <= '0;
            olast_q     <= 1'b0;
            bad_magic_q <= 16'd0;
            seq_err_q   <= 16'd0;
            unknown_q   <= 16'd0;
            short_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            seq_valid_q <= seq_valid_d;
            prev_seq_q  <= prev_seq_d;
            mask_q      <= mask_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            otype_q     <= otype_d;
            oidx_q      <= oidx_d;
            olast_q     <= olast_d;
            bad_magic_q <= bad_magic_d;
            seq_err_q   <= seq_err_d;
            unknown_q   <= unknown_d;
            short_q     <= short_d;
        end
    end

    // Message parser: next state, header context, payload forwarding and error counts
    always_comb begin
        state_d     = state_q;
        seq_valid_d = seq_valid_q;
        prev_seq_d  = prev_seq_q;
        mask_d      = mask_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        valid_d     = '0;
        data_d      = data_q;
        otype_d     = otype_q;
        oidx_d      = oidx_q;
        olast_d     = 1'b0;
        bad_magic_d = bad_magic_q;
        seq_err_d   = seq_err_q;
        unknown_d   = unknown_q;
        short_d     = short_q;

        if (accept_s) begin
            case (state_q)
                S_MAGIC: begin
                    if (bus.S_axis_data == MAGIC_NUM) begin
                        if (last_s) begin
                            short_d = sat_inc(short_q);
                            state_d = S_MAGIC;
                        end else begin
                            state_d = S_SEQ;
                        end
                    end else begin
                        bad_magic_d = sat_inc(bad_magic_q);
                        state_d     = last_s ? S_MAGIC : S_DROP;
                    end
                end
                S_SEQ: begin
                    // A gap is counted but the message is still delivered
                    if (seq_valid_q && (bus.S_axis_data != (prev_seq_q + 32'd1))) begin
                        seq_err_d = sat_inc(seq_err_q);
                    end else begin
                        seq_err_d = seq_err_q;
                    end
                    prev_seq_d  = bus.S_axis_data;
                    seq_valid_d = 1'b1;
                    if (last_s) begin
                        short_d = sat_inc(short_q);
                        state_d = S_MAGIC;
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    type_d = bus.S_axis_data[23:16];
                    if (hdr_id_s == BROADCAST_ID) begin
                        mask_d = '1;
                    end else if (32'(hdr_id_s) < NUM_MODULES) begin
                        mask_d = ONE_HOT << hdr_id_s;
                    end else begin
                        mask_d    = '0;
                        unknown_d = sat_inc(unknown_q);
                    end
                    if (last_s) begin
                        short_d = sat_inc(short_q);
                        state_d = S_MAGIC;
                    end else if (mask_d == '0) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_PAD;
                    end
                end
                S_PAD: begin
                    cnt_d = '0;
                    if (last_s) begin
                        short_d = sat_inc(short_q);
                        state_d = S_MAGIC;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    valid_d = mask_q;
                    data_d  = bus.S_axis_data;
                    otype_d = type_q;
                    oidx_d  = cnt_q;
                    olast_d = last_s | (cnt_q == LAST_IDX);
                    if (last_s) begin
                        state_d = S_MAGIC;
                    end else if (cnt_q == LAST_IDX) begin
                        short_d = sat_inc(short_q);
                        state_d = S_DROP;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
                S_DROP: begin
                    state_d = last_s ? S_MAGIC : S_DROP;
                end
                default: begin
                    state_d = S_MAGIC;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign bus.S_axis_ready       = ready_q;
    assign bus.Module_valid       = valid_q;
    assign bus.Module_data        = data_q;
    assign bus.Module_msg_type    = otype_q;
    assign bus.Module_word_index  = oidx_q;
    assign bus.Module_last        = olast_q;
    assign bus.Err_bad_magic      = bad_magic_q;
    assign bus.Err_seq            = seq_err_q;
    assign bus.Err_unknown_module = unknown_q;
    assign bus.Err_short_overlong = short_q;

endmodule

// File: tb/tb_esm_config_router.sv
// Directed bench for esm_config_router: header parsing, fan-out, error counters, overlong and reset recovery.
module tb_esm_config_router;

    localparam int unsigned NM    = 4;
    localparam int unsigned MAXW  = 64;
    localparam int unsigned IW    = 6;
    localparam logic [31:0] MAGIC = 32'hE5C0_0F1C;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    esm_config_router_if #(.NUM_MODULES(NM), .IDX_W(IW)) bus ();

    esm_config_router #(
        .NUM_MODULES      (NM),
        .MAX_PAYLOAD_WORDS(MAXW),
        .MAGIC_NUM        (MAGIC),
        .BROADCAST_ID     (8'hFF),
        .IDX_W            (IW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bus.S_axis_valid = 1'b1;
        bus.S_axis_data  = d;
        bus.S_axis_last  = l;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.S_axis_valid = 1'b0;
        bus.S_axis_last  = 1'b0;
        @(posedge Clk);
        #1;
        chk("idle_valid", 32'(bus.Module_valid), 32'd0);
    endtask

    task automatic do_reset();
        bus.S_axis_valid = 1'b0;
        bus.S_axis_last  = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic header(input logic [31:0] seq, input logic [7:0] id, input logic [7:0] mt);
        send(MAGIC, 1'b0);
        send(seq, 1'b0);
        send({id, mt, 16'h0000}, 1'b0);
        send(32'h0, 1'b0);
        chk("hdr_no_out", 32'(bus.Module_valid), 32'd0);
    endtask

    task automatic payload(input logic [31:0] d, input logic l, input logic [NM-1:0] m,
                           input int idx, input logic el, input logic [7:0] mt);
        send(d, l);
        chk("pl_valid", 32'(bus.Module_valid), 32'(m));
        if (m != '0) begin
            chk("pl_data", bus.Module_data, d);
            chk("pl_index", 32'(bus.Module_word_index), 32'(idx));
            chk("pl_last", 32'(bus.Module_last), 32'(el));
            chk("pl_type", 32'(bus.Module_msg_type), 32'(mt));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.S_axis_valid = 1'b0;
        bus.S_axis_data  = 32'd0;
        bus.S_axis_last  = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ready", 32'(bus.S_axis_ready), 32'd0);
        chk("rst_valid", 32'(bus.Module_valid), 32'd0);
        chk("rst_data", bus.Module_data, 32'd0);
        chk("rst_errs", {bus.Err_bad_magic, bus.Err_seq}, 32'd0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("ready_up", 32'(bus.S_axis_ready), 32'd1);

        // Test 1: unicast to port 1, five words
        header(32'd0, 8'd1, 8'd2);
        for (int i = 0; i < 5; i++) begin
            payload(32'hA000_0000 + 32'(i), (i == 4), 4'b0010, i, (i == 4), 8'd2);
        end
        idle();
        chk("t1_held_data", bus.Module_data, 32'hA000_0004);
        chk("t1_errs", {bus.Err_bad_magic, bus.Err_seq}, 32'd0);
        chk("t1_errs2", {bus.Err_unknown_module, bus.Err_short_overlong}, 32'd0);

        // Test 2: sequence gap 7 -> 9
        do_reset();
        header(32'd7, 8'd2, 8'd3);
        payload(32'hB000_0001, 1'b1, 4'b0100, 0, 1'b1, 8'd3);
        header(32'd9, 8'd2, 8'd3);
        payload(32'hB000_0002, 1'b1, 4'b0100, 0, 1'b1, 8'd3);
        chk("t2_seq", 32'(bus.Err_seq), 32'd1);

        // Test 3: bad magic message then a good one
        do_reset();
        send(32'h1234_5678, 1'b0);
        for (int i = 1; i < 6; i++) begin
            send(32'hC000_0000 + 32'(i), (i == 5));
            chk("t3_drop", 32'(bus.Module_valid), 32'd0);
        end
        header(32'd1, 8'd0, 8'd4);
        payload(32'hC100_0000, 1'b0, 4'b0001, 0, 1'b0, 8'd4);
        payload(32'hC100_0001, 1'b1, 4'b0001, 1, 1'b1, 8'd4);
        chk("t3_magic", 32'(bus.Err_bad_magic), 32'd1);

        // Test 4: broadcast
        do_reset();
        header(32'd3, 8'hFF, 8'd5);
        for (int i = 0; i < 3; i++) begin
            payload(32'hD000_0000 + 32'(i), (i == 2), 4'b1111, i, (i == 2), 8'd5);
        end

        // Test 5: overlong message, then a normal one
        do_reset();
        header(32'd0, 8'd3, 8'd1);
        for (int i = 0; i < MAXW + 4; i++) begin
            payload(32'hE000_0000 + 32'(i), (i == MAXW + 3), (i < MAXW) ? 4'b1000 : 4'b0000,
                    i, (i == MAXW - 1), 8'd1);
        end
        chk("t5_overlong", 32'(bus.Err_short_overlong), 32'd1);
        header(32'd1, 8'd0, 8'd6);
        payload(32'hE100_0000, 1'b1, 4'b0001, 0, 1'b1, 8'd6);
        chk("t5_seq", 32'(bus.Err_seq), 32'd0);

        // Test 6: reset in the middle of a payload
        do_reset();
        header(32'd5, 8'd1, 8'd0);
        for (int i = 0; i < 3; i++) begin
            payload(32'hF000_0000 + 32'(i), 1'b0, 4'b0010, i, 1'b0, 8'd0);
        end
        bus.S_axis_valid = 1'b0;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("t6_valid", 32'(bus.Module_valid), 32'd0);
        chk("t6_data", bus.Module_data, 32'd0);
        chk("t6_idx", 32'(bus.Module_word_index), 32'd0);
        chk("t6_errs", {bus.Err_bad_magic, bus.Err_seq}, 32'd0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        payload(32'hF000_0003, 1'b0, 4'b0000, 0, 1'b0, 8'd0);
        payload(32'hF000_0004, 1'b1, 4'b0000, 0, 1'b0, 8'd0);
        chk("t6_magic", 32'(bus.Err_bad_magic), 32'd1);
        header(32'd100, 8'd2, 8'd7);
        payload(32'hF100_0000, 1'b1, 4'b0100, 0, 1'b1, 8'd7);
        chk("t6_seq", 32'(bus.Err_seq), 32'd0);

        // Test 7: header-only short message and an unknown destination
        do_reset();
        send(MAGIC, 1'b0);
        send(32'd1, 1'b1);
        chk("t7_short", 32'(bus.Err_short_overlong), 32'd1);
        header(32'd2, 8'd9, 8'd1);
        chk("t7_unknown", 32'(bus.Err_unknown_module), 32'd1);
        payload(32'h1111_1111, 1'b1, 4'b0000, 0, 1'b0, 8'd1);
        header(32'd3, 8'd3, 8'd2);
        payload(32'h2222_2222, 1'b1, 4'b1000, 0, 1'b1, 8'd2);
        chk("t7_seq", 32'(bus.Err_seq), 32'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
